trk_nco: RTL and testbench

Code and carrier numerically controlled oscillator for one B1 tracking channel. Consumes the 32-bit code and carrier frequency control words produced by the tracking loop filter and generates the chip strobe, chip index, carrier phase and the one-cycle PRN epoch pulse (`tx_prn_sop`). That pulse is the `rx_prn_sop` that clocks the loop filter and the correlator dump, which closes the loop. A load port lets acquisition hand over initial code and carrier phase.

---
 rtl/trk_nco_if.sv | 38 +++
 rtl/trk_nco.sv | 98 +++++++++
 tb/tb_trk_nco.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/trk_nco_if.sv
// Code/carrier NCO bus: FCW and phase-load inputs toward the NCO, chip/phase outputs back.
// Latency: n/a (signal bundle only).
// Backpressure: none; every signal is sampled or produced once per rx_clk cycle.
//
// Ports (slave = NCO side, master = loop filter / acquisition / correlator side):
//   rx_prn_fcw, rx_car_fcw        32-bit code and carrier frequency control words
//   rx_load, rx_load_chip/_car    one-cycle initial-phase load
//   tx_prn_sop, tx_chip_en        one-cycle epoch and chip-advance strobes
//   tx_chip_idx, tx_code_phase    chip index and fractional code phase
//   tx_car_phase, tx_car_quad     carrier phase and its top two bits
//   tx_epoch_cnt                  epochs since last load or reset
interface trk_nco_if;
  logic [31:0] rx_prn_fcw;
  logic [31:0] rx_car_fcw;
  logic        rx_load;
  logic [13:0] rx_load_chip;
  logic [31:0] rx_load_car;

  logic        tx_prn_sop;
  logic        tx_chip_en;
  logic [13:0] tx_chip_idx;
  logic [31:0] tx_code_phase;
  logic [31:0] tx_car_phase;
  logic [1:0]  tx_car_quad;
  logic [15:0] tx_epoch_cnt;

  modport master (
    output rx_prn_fcw, rx_car_fcw, rx_load, rx_load_chip, rx_load_car,
    input  tx_prn_sop, tx_chip_en, tx_chip_idx, tx_code_phase, tx_car_phase,
           tx_car_quad, tx_epoch_cnt
  );

  modport slave (
    input  rx_prn_fcw, rx_car_fcw, rx_load, rx_load_chip, rx_load_car,
    output tx_prn_sop, tx_chip_en, tx_chip_idx, tx_code_phase, tx_car_phase,
           tx_car_quad, tx_epoch_cnt
  );
endinterface

// File: rtl/trk_nco.sv
// Code and carrier NCO for one B1 tracking channel; emits chip strobe/index, carrier phase, epoch pulse.
// Latency: all outputs registered; load visible 1 cycle later, FCW change affects phase 2 edges later.
// Backpressure: none; free-running every rx_clk cycle, rx_load overrides accumulation.
//
// Ports:
//   rx_clk   clock, all logic on its rising edge
//   rx_rst   synchronous active-high reset; clears every register including the active FCWs
//   nco      trk_nco_if.slave bus (FCW/load inputs, chip/phase/epoch outputs)
// Parameter CODE_LEN: chips per PRN epoch (2..16383).
// Build option TRK_NCO_EPOCH_ALIGN_EN: when defined, the active FCWs are only adopted at
// load and at the epoch-wrap edge, so the rate is constant across each PRN epoch.
module trk_nco #(
  parameter int CODE_LEN = 2046
) (
  input  logic     rx_clk,
  input  logic     rx_rst,
  trk_nco_if.slave nco
);

  localparam logic [13:0] LAST_CHIP = 14'(CODE_LEN - 1);
  localparam logic [13:0] LEN_W     = 14'(CODE_LEN);

  logic [31:0] prn_fcw_a;
  logic [31:0] car_fcw_a;
  logic [31:0] code_acc;
  logic [31:0] car_acc;
  logic [13:0] chip_idx;
  logic [15:0] epoch_cnt;
  logic        chip_en;
  logic        prn_sop;

  logic [32:0] code_sum;
  logic        carry;
  logic        wrap;
  logic [13:0] load_idx;

  always_comb begin
    code_sum = {1'b0, code_acc} + {1'b0, prn_fcw_a};
    carry    = code_sum[32];
    wrap     = carry && (chip_idx == LAST_CHIP);
    // Out-of-range load index falls back to chip 0 rather than an illegal index.
    load_idx = (nco.rx_load_chip >= LEN_W) ? 14'd0 : nco.rx_load_chip;
  end

  // Active FCWs: the accumulators only ever see these registered copies.
  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      prn_fcw_a <= '0;
      car_fcw_a <= '0;
`ifdef TRK_NCO_EPOCH_ALIGN_EN
    end else if (nco.rx_load || wrap) begin
`else
    end else begin
`endif
      prn_fcw_a <= nco.rx_prn_fcw;
      car_fcw_a <= nco.rx_car_fcw;
    end
  end

  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      code_acc  <= '0;
      car_acc   <= '0;
      chip_idx  <= '0;
      epoch_cnt <= '0;
      chip_en   <= 1'b0;
      prn_sop   <= 1'b0;
    end else if (nco.rx_load) begin
      // Load wins over any carry in the same cycle; strobes are suppressed.
      code_acc  <= '0;
      car_acc   <= nco.rx_load_car;
      chip_idx  <= load_idx;
      epoch_cnt <= '0;
      chip_en   <= 1'b0;
      prn_sop   <= 1'b0;
    end else begin
      code_acc <= code_sum[31:0];
      car_acc  <= car_acc + car_fcw_a;
      chip_en  <= carry;
      prn_sop  <= wrap;
      if (wrap) begin
        chip_idx  <= '0;
        epoch_cnt <= epoch_cnt + 16'd1;
      end else if (carry) begin
        chip_idx <= chip_idx + 14'd1;
      end
    end
  end

  assign nco.tx_prn_sop    = prn_sop;
  assign nco.tx_chip_en    = chip_en;
  assign nco.tx_chip_idx   = chip_idx;
  assign nco.tx_code_phase = code_acc;
  assign nco.tx_car_phase  = car_acc;
  assign nco.tx_car_quad   = car_acc[31:30];
  assign nco.tx_epoch_cnt  = epoch_cnt;

endmodule

// File: tb/tb_trk_nco.sv
module tb_trk_nco;

  localparam int LEN = 4;

  logic rx_clk = 1'b0;
  logic rx_rst;

  trk_nco_if bus();

  trk_nco #(.CODE_LEN(LEN)) dut (
    .rx_clk (rx_clk),
    .rx_rst (rx_rst),
    .nco    (bus)
  );

  always #5 rx_clk = ~rx_clk;

  typedef struct packed {
    logic        sop;
    logic        en;
    logic [13:0] idx;
    logic [31:0] code;
    logic [31:0] car;
    logic [1:0]  quad;
    logic [15:0] ep;
  } obs_t;

  typedef struct {
    logic        load;
    logic [13:0] chip;
    logic [31:0] car;
    obs_t        exp;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: chip position as integers, phases as 64-bit sums reduced mod 2^32.
  longint unsigned m_pfcw, m_cfcw, m_code, m_car;
  int              m_chip, m_ep;
  bit              m_en, m_sop;

  task automatic model_edge();
    longint unsigned s;
    bit adopt;
    if (rx_rst) begin
      m_pfcw = 0; m_cfcw = 0; m_code = 0; m_car = 0;
      m_chip = 0; m_ep = 0; m_en = 0; m_sop = 0;
      return;
    end
    if (bus.rx_load) begin
      m_code = 0;
      m_chip = (int'(bus.rx_load_chip) >= LEN) ? 0 : int'(bus.rx_load_chip);
      m_car  = longint'(bus.rx_load_car);
      m_ep   = 0;
      m_en   = 0;
      m_sop  = 0;
    end else begin
      s      = m_code + m_pfcw;
      m_en   = (s >= 64'h1_0000_0000);
      m_code = s % 64'h1_0000_0000;
      m_sop  = 0;
      if (m_en) begin
        m_chip = (m_chip + 1) % LEN;
        if (m_chip == 0) begin
          m_sop = 1;
          m_ep  = (m_ep + 1) % 65536;
        end
      end
      m_car = (m_car + m_cfcw) % 64'h1_0000_0000;
    end
`ifdef TRK_NCO_EPOCH_ALIGN_EN
    adopt = bus.rx_load || m_sop;
`else
    adopt = 1'b1;
`endif
    if (adopt) begin
      m_pfcw = longint'(bus.rx_prn_fcw);
      m_cfcw = longint'(bus.rx_car_fcw);
    end
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.sop  = m_sop;
    o.en   = m_en;
    o.idx  = 14'(m_chip);
    o.code = 32'(m_code);
    o.car  = 32'(m_car);
    o.quad = 2'(m_car >> 30);
    o.ep   = 16'(m_ep);
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.sop  = bus.tx_prn_sop;
    o.en   = bus.tx_chip_en;
    o.idx  = bus.tx_chip_idx;
    o.code = bus.tx_code_phase;
    o.car  = bus.tx_car_phase;
    o.quad = bus.tx_car_quad;
    o.ep   = bus.tx_epoch_cnt;
    return o;
  endfunction

  task automatic step();
    model_edge();
    @(posedge rx_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_obs(input string name, input obs_t act, input obs_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got sop=%b en=%b idx=%0d code=%h car=%h quad=%0d ep=%0d expected sop=%b en=%b idx=%0d code=%h car=%h quad=%0d ep=%0d",
               name, act.sop, act.en, act.idx, act.code, act.car, act.quad, act.ep,
               exp.sop, exp.en, exp.idx, exp.code, exp.car, exp.quad, exp.ep);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t tbl [17];

  initial begin
    logic [31:0] mask, exp_mask;
    obs_t zero;
    zero = '0;

    // Code-rate + carrier vectors: load chip 0 / car 0, fcw 1/2 chip per cycle, carrier 1/4 turn.
    tbl[0].load = 1'b1; tbl[0].chip = 14'd0; tbl[0].car = 32'd0; tbl[0].exp = '0;
    for (int n = 1; n < 17; n++) begin
      int chips;
      chips = n / 2;
      tbl[n].load     = 1'b0;
      tbl[n].chip     = 14'd0;
      tbl[n].car      = 32'd0;
      tbl[n].exp.en   = (n % 2 == 0);
      tbl[n].exp.idx  = 14'(chips % 4);
      tbl[n].exp.sop  = (n % 2 == 0) && (chips % 4 == 0);
      tbl[n].exp.code = (n % 2 == 1) ? 32'h8000_0000 : 32'h0;
      tbl[n].exp.car  = 32'(n) << 30;
      tbl[n].exp.quad = 2'(n % 4);
      tbl[n].exp.ep   = 16'(chips / 4);
    end

    rx_rst = 1'b1;
    bus.rx_prn_fcw   = 32'h0;
    bus.rx_car_fcw   = 32'h0;
    bus.rx_load      = 1'b0;
    bus.rx_load_chip = 14'd0;
    bus.rx_load_car  = 32'd0;
    step();
    step();
    chk_obs("reset_state", dut_obs(), zero);

    rx_rst = 1'b0;
    bus.rx_prn_fcw = 32'h8000_0000;
    bus.rx_car_fcw = 32'h4000_0000;
    for (int i = 0; i < 17; i++) begin
      bus.rx_load      = tbl[i].load;
      bus.rx_load_chip = tbl[i].chip;
      bus.rx_load_car  = tbl[i].car;
      step();
      chk_obs($sformatf("rate_row%0d", i), dut_obs(), tbl[i].exp);
    end
    bus.rx_load = 1'b0;

    // Load/wrap collision at one chip per cycle.
    bus.rx_prn_fcw   = 32'hFFFF_FFFF;
    bus.rx_load      = 1'b1;
    bus.rx_load_chip = 14'd3;
    step();
    bus.rx_load = 1'b0;
    chk("coll_load_idx", 64'(bus.tx_chip_idx), 64'd3);
    step();
    chk("coll_first_code", 64'(bus.tx_code_phase), 64'hFFFF_FFFF);
    step();
    chk("coll_wrap_sop", 64'({bus.tx_prn_sop, bus.tx_chip_en, bus.tx_chip_idx, bus.tx_epoch_cnt}),
        64'({1'b1, 1'b1, 14'd0, 16'd1}));
    step();
    step();
    step();
    chk("coll_at_idx3", 64'({bus.tx_chip_en, bus.tx_chip_idx}), 64'({1'b1, 14'd3}));
    bus.rx_load      = 1'b1;
    bus.rx_load_chip = 14'd2;
    step();
    chk("coll_load_wins", 64'({bus.tx_prn_sop, bus.tx_chip_en, bus.tx_chip_idx, bus.tx_epoch_cnt, bus.tx_code_phase}),
        64'({1'b0, 1'b0, 14'd2, 16'd0, 32'd0}));
    bus.rx_load_chip = 14'd5;
    step();
    chk("load_out_of_range", 64'({bus.tx_prn_sop, bus.tx_chip_en, bus.tx_chip_idx}), 64'({1'b0, 1'b0, 14'd0}));
    bus.rx_load = 1'b0;

    // Mid-epoch FCW change: chip strobe cycles recorded relative to the load.
    bus.rx_prn_fcw   = 32'h8000_0000;
    bus.rx_load      = 1'b1;
    bus.rx_load_chip = 14'd0;
    step();
    bus.rx_load = 1'b0;
    step(); step(); step();
    bus.rx_prn_fcw = 32'h4000_0000;
    mask = '0;
    for (int n = 4; n < 15; n++) begin
      step();
      mask[n] = bus.tx_chip_en;
    end
`ifdef TRK_NCO_EPOCH_ALIGN_EN
    exp_mask = (32'd1 << 4) | (32'd1 << 6) | (32'd1 << 8) | (32'd1 << 12);
`else
    exp_mask = (32'd1 << 4) | (32'd1 << 8) | (32'd1 << 12);
`endif
    chk("fcw_change_chip_mask", 64'(mask), 64'(exp_mask));

    // Reset mid-operation.
    bus.rx_car_fcw = 32'h1000_0000;
    step();
    rx_rst = 1'b1;
    bus.rx_load = 1'b1;
    bus.rx_load_chip = 14'd3;
    step();
    bus.rx_load = 1'b0;
    chk_obs("reset_midrun", dut_obs(), zero);
    rx_rst = 1'b0;
    step();
    chk("rst_edge1_frozen", 64'({bus.tx_code_phase, bus.tx_car_phase}), 64'd0);
    step();
`ifdef TRK_NCO_EPOCH_ALIGN_EN
    chk("rst_edge2", 64'({bus.tx_code_phase, bus.tx_car_phase}), 64'd0);
`else
    chk("rst_edge2", 64'({bus.tx_code_phase, bus.tx_car_phase}), {32'h4000_0000, 32'h1000_0000});
`endif
    bus.rx_load      = 1'b1;
    bus.rx_load_chip = 14'd1;
    bus.rx_load_car  = 32'h0;
    step();
    bus.rx_load = 1'b0;
    step();
    chk("post_load_advance", 64'({bus.tx_chip_idx, bus.tx_code_phase}), 64'({14'd1, 32'h4000_0000}));

    // Randomized run against the reference model.
    for (int i = 0; i < 3000; i++) begin
      rx_rst      = ($urandom_range(0, 63) == 0);
      bus.rx_load = ($urandom_range(0, 15) == 0);
      bus.rx_load_chip = 14'($urandom_range(0, 7));
      bus.rx_load_car  = $urandom;
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0:       bus.rx_prn_fcw = $urandom;
          1:       bus.rx_prn_fcw = 32'hFFFF_FFFF;
          2:       bus.rx_prn_fcw = 32'h8000_0000;
          default: bus.rx_prn_fcw = 32'hC000_0000 + 32'($urandom_range(0, 1000));
        endcase
        bus.rx_car_fcw = $urandom;
      end
      step();
      chk_obs($sformatf("rand_cycle%0d", i), dut_obs(), model_obs());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
